// File: rtl/snn_pkg.sv
// -----------------------------------------------------------------------------
// snn_pkg
// Shared types and helpers for the spiking-neuron datapath (synaptic current
// stage and QIF neuron).
//   SYN_W    : width of the signed synaptic current / weights
//   syn_t    : signed SYN_W-bit value
//   sat_res_t: saturated value plus a flag that is set when clamping occurred
//   sat8()   : clamp a wide signed accumulator into syn_t range [-128, 127]
// -----------------------------------------------------------------------------
package snn_pkg;

    localparam int SYN_W    = 8;
    // Widest accumulator any caller hands to sat8(); narrower callers sign-extend.
    localparam int SAT_IN_W = 16;

    typedef logic signed [SYN_W-1:0] syn_t;

    typedef struct packed {
        syn_t val;
        logic ovf;
    } sat_res_t;

    function automatic sat_res_t sat8(input logic signed [SAT_IN_W-1:0] acc);
        localparam logic signed [SAT_IN_W-1:0] SYN_MAX = 127;
        localparam logic signed [SAT_IN_W-1:0] SYN_MIN = -128;
        sat_res_t r;
        r.val = acc[SYN_W-1:0];
        r.ovf = 1'b0;
        if (acc > SYN_MAX) begin
            r.val = 8'sd127;
            r.ovf = 1'b1;
        end else if (acc < SYN_MIN) begin
            r.val = -8'sd128;
            r.ovf = 1'b1;
        end
        return r;
    endfunction

endpackage

// File: rtl/syn_weight_rf.sv
// -----------------------------------------------------------------------------
// syn_weight_rf
// N_IN x SYN_W signed weight register file, one write port, all entries read
// in parallel through a flattened bus.
//   clk, rst_n : clock, asynchronous active-high reset (clears all weights)
//   w_we       : write enable
//   w_addr     : write index; indices >= N_IN are ignored
//   w_data     : signed weight to write
//   w_flat     : all weights, entry i at bits [i*SYN_W +: SYN_W]
// -----------------------------------------------------------------------------
module syn_weight_rf
    import snn_pkg::*;
#(
    parameter int N_IN = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      w_we,
    input  logic [$clog2(N_IN)-1:0]   w_addr,
    input  logic [SYN_W-1:0]          w_data,
    output logic [N_IN*SYN_W-1:0]     w_flat
);

    syn_t w_q [N_IN];

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            for (int i = 0; i < N_IN; i++) w_q[i] <= '0;
        end else if (w_we && (int'(w_addr) < N_IN)) begin
            // Guard matters only when N_IN is not a power of two.
            w_q[w_addr] <= w_data;
        end
    end

    always_comb begin
        w_flat = '0;
        for (int i = 0; i < N_IN; i++) w_flat[i*SYN_W +: SYN_W] = w_q[i];
    end

endmodule

// File: rtl/syn_current_8b.sv
// -----------------------------------------------------------------------------
// syn_current_8b
// Leaky synaptic current integrator feeding the QIF neuron's I_syn input.
// Spikes are latched between update strobes; on each tick the current decays
// by I >>> DECAY_SHIFT, the weights of all hit inputs are added, and the
// result is clamped to 8 bits.
//   clk, rst_n : clock, asynchronous active-high reset
//   spike_in   : presynaptic spike pulses, one bit per input
//   tick       : update strobe
//   w_we/w_addr/w_data : weight write port
//   I_syn      : registered signed current
//   sat        : set for the update whose result was clamped
// -----------------------------------------------------------------------------
module syn_current_8b
    import snn_pkg::*;
#(
    parameter int N_IN        = 4,
    parameter int DECAY_SHIFT = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N_IN-1:0]         spike_in,
    input  logic                    tick,
    input  logic                    w_we,
    input  logic [$clog2(N_IN)-1:0] w_addr,
    input  logic [SYN_W-1:0]        w_data,
    output logic [SYN_W-1:0]        I_syn,
    output logic                    sat
);

    localparam int ACC_W = SYN_W + $clog2(N_IN) + 1;

    logic [N_IN*SYN_W-1:0] w_flat;
    logic [N_IN-1:0]       pend;
    logic [N_IN-1:0]       hit_p0;
    syn_t                  cur_p0;
    syn_t                  wi_p0;
    logic signed [ACC_W-1:0]    acc_p0;
    logic signed [SAT_IN_W-1:0] acc16_p0;
    sat_res_t              res_p0;

    syn_weight_rf #(.N_IN(N_IN)) u_rf (
        .clk    (clk),
        .rst_n  (rst_n),
        .w_we   (w_we),
        .w_addr (w_addr),
        .w_data (w_data),
        .w_flat (w_flat)
    );

    // Spike latch: a repeat spike before the tick collapses into one hit.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n)     pend <= '0;
        else if (tick) pend <= '0;
        else           pend <= pend | spike_in;
    end

    // Stage 0: decay + weighted sum. The RF still holds the pre-write weight
    // during a colliding write, so the update naturally uses the old value.
    always_comb begin
        hit_p0 = pend | spike_in;
        cur_p0 = I_syn;
        wi_p0  = '0;
        acc_p0 = ACC_W'(cur_p0) - ACC_W'(cur_p0 >>> DECAY_SHIFT);
        for (int i = 0; i < N_IN; i++) begin
            wi_p0 = w_flat[i*SYN_W +: SYN_W];
            if (hit_p0[i]) acc_p0 = acc_p0 + ACC_W'(wi_p0);
        end
        acc16_p0 = SAT_IN_W'(acc_p0);
        res_p0   = sat8(acc16_p0);
    end

    // Stage 1: output registers, loaded only on tick.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            I_syn <= '0;
            sat   <= 1'b0;
        end else if (tick) begin
            I_syn <= res_p0.val;
            sat   <= res_p0.ovf;
        end
    end

endmodule

// File: tb/tb_syn_current_8b.sv
module tb_syn_current_8b;

    localparam int N_IN = 4;
    localparam int DS   = 2;
    localparam int AW   = $clog2(N_IN);

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N_IN-1:0] spike_in;
    logic            tick;
    logic            w_we;
    logic [AW-1:0]   w_addr;
    logic [7:0]      w_data;
    logic [7:0]      I_syn;
    logic            sat;

    syn_current_8b #(.N_IN(N_IN), .DECAY_SHIFT(DS)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .spike_in (spike_in),
        .tick     (tick),
        .w_we     (w_we),
        .w_addr   (w_addr),
        .w_data   (w_data),
        .I_syn    (I_syn),
        .sat      (sat)
    );

    always #5 clk = ~clk;

    typedef struct {
        int i;
        bit s;
    } exp_t;

    exp_t            sb[$];
    int              m_i;
    int              m_w [N_IN];
    logic [N_IN-1:0] m_pend;
    int              n_chk  = 0;
    int              n_pass = 0;
    string           phase  = "init";

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_chk++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s/%s got=%0d exp=%0d", phase, tag, $signed(got), $signed(exp));
    endtask

    // Drive one cycle; the reference model computes the expected update and
    // pushes it to the scoreboard, which is popped after the edge.
    task automatic step(input logic [N_IN-1:0] sp, input logic tk,
                        input logic we = 1'b0, input int a = 0, input int d = 0);
        exp_t e;
        int   acc;
        logic [N_IN-1:0] hit;
        spike_in = sp;
        tick     = tk;
        w_we     = we;
        w_addr   = AW'(a);
        w_data   = 8'(d);
        if (tk) begin
            hit = m_pend | sp;
            acc = m_i - (m_i >>> DS);
            for (int k = 0; k < N_IN; k++) if (hit[k]) acc += m_w[k];
            if (acc > 127)       begin e.i = 127;  e.s = 1'b1; end
            else if (acc < -128) begin e.i = -128; e.s = 1'b1; end
            else                 begin e.i = acc;  e.s = 1'b0; end
            sb.push_back(e);
            m_i    = e.i;
            m_pend = '0;
        end else begin
            m_pend = m_pend | sp;
        end
        if (we && a < N_IN) m_w[a] = d;
        @(posedge clk);
        #1;
        if (tk) begin
            e = sb.pop_front();
            chk("I_syn", I_syn, 8'(e.i));
            chk("sat", {7'b0, sat}, {7'b0, e.s});
        end else begin
            chk("hold", I_syn, 8'(m_i));
        end
    endtask

    // Asynchronous reset asserted between edges; outputs must clear at once.
    task automatic do_reset();
        spike_in = '0; tick = 1'b0; w_we = 1'b0;
        rst_n = 1'b1;
        m_i = 0; m_pend = '0;
        for (int k = 0; k < N_IN; k++) m_w[k] = 0;
        #2;
        chk("rst_I_syn", I_syn, 8'd0);
        chk("rst_sat", {7'b0, sat}, 8'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; spike_in = '0; tick = 1'b0;
        w_we = 1'b0; w_addr = '0; w_data = '0;
        @(posedge clk); #1;
        do_reset();

        phase = "idle";
        for (int k = 0; k < 10; k++) step('0, 1'b1);

        phase = "single";
        step('0, 1'b0, 1'b1, 0, 20);
        step(4'b0001, 1'b1);                      // 20
        for (int k = 0; k < 4; k++) step('0, 1'b1); // 15 12 9 7

        phase = "latch";
        do_reset();
        step('0, 1'b0, 1'b1, 1, -10);
        step(4'b0010, 1'b0);
        step('0, 1'b0);
        step(4'b0010, 1'b0);
        step('0, 1'b1);                           // -10, counted once
        step('0, 1'b1);                           // -10 - (-3) = -7

        phase = "pos_sat";
        do_reset();
        for (int k = 0; k < N_IN; k++) step('0, 1'b0, 1'b1, k, 100);
        step('1, 1'b1);                           // 127, sat
        step('0, 1'b1);                           // 96

        phase = "neg_sat";
        for (int k = 0; k < N_IN; k++) step('0, 1'b0, 1'b1, k, -128);
        step('1, 1'b1);                           // -128, sat
        step(4'b0001, 1'b1, 1'b1, 0, 50);         // old weight: -128, sat
        step(4'b0001, 1'b1);                      // -46

        phase = "mid_rst";
        do_reset();
        step('0, 1'b0, 1'b1, 0, 40);
        step('0, 1'b0, 1'b1, 1, 30);
        step(4'b0001, 1'b1);                      // 40
        step(4'b0011, 1'b0);                      // pending spikes
        do_reset();
        step('0, 1'b1);                           // 0: pend and weights gone
        step(4'b0011, 1'b1);                      // still 0

        phase = "end";
        chk("sb_empty", 8'(sb.size()), 8'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
